control_sequencer_legv8: RTL and testbench

CONTROL_SEQUENCER_LEGV8 -- requirements
Module: control_sequencer_legv8

---
 rtl/control_sequencer_legv8.sv | 212 +++++++++++++++++++++
 tb/tb_control_sequencer_legv8.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_legv8.sv
// Three-cycle FETCH/DECODE/EXECUTE control sequencer for a LEGv8 datapath.
// Optional build macro FLAG_BRANCH_EN enables B.cond decoding; without it B.cond halts.
module control_sequencer_legv8 #(
  parameter int unsigned LINK_REG = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_i,
  input  logic [4:0]  status_i,
  output logic [29:0] control_word_o,
  output logic [63:0] constant_o,
  output logic [1:0]  state_o,
  output logic        halt_o
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_DECODE  = 2'b01,
    S_EXECUTE = 2'b10,
    S_HALT    = 2'b11
  } state_e;

  typedef struct packed {
    logic       en_pc;
    logic       en_mem;
    logic       en_alu;
    logic       pc_sel;
    logic       b_sel;
    logic       sl;
    logic       wm;
    logic       wr;
    logic [1:0] ps;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } cw_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_REG    = 2'b10;
  localparam logic [1:0] PS_BRANCH = 2'b11;

  localparam logic [4:0] LINK_DA = 5'(LINK_REG);
  localparam logic [4:0] XZR     = 5'd31;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [63:0] constant_q;

  cw_t         exec_cw;
  logic [63:0] const_d;
  logic        valid;
  logic        alu_rr;
  logic        alu_ri;

`ifdef FLAG_BRANCH_EN
  // Condition codes evaluated on the registered flags {V,C,N,Z} = status_i[4:1].
  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] vcnz);
    logic v, c, n, z;
    {v, c, n, z} = vcnz;
    unique case (cond)
      4'h0: cond_taken = z;
      4'h1: cond_taken = !z;
      4'h2: cond_taken = c;
      4'h3: cond_taken = !c;
      4'h4: cond_taken = n;
      4'h5: cond_taken = !n;
      4'h6: cond_taken = v;
      4'h7: cond_taken = !v;
      4'h8: cond_taken = c && !z;
      4'h9: cond_taken = !(c && !z);
      4'hA: cond_taken = (n == v);
      4'hB: cond_taken = (n != v);
      4'hC: cond_taken = !z && (n == v);
      4'hD: cond_taken = !(!z && (n == v));
      default: cond_taken = 1'b1;
    endcase
  endfunction
`else
  logic unused_flags;
  assign unused_flags = ^status_i[4:1];
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    exec_cw = '0;
    const_d = '0;
    valid   = 1'b1;
    alu_rr  = 1'b0;
    alu_ri  = 1'b0;
    casez (ir_q[31:21])
      11'b000101?????, 11'b100101?????: begin
        exec_cw.pc_sel = 1'b1;
        exec_cw.ps     = PS_BRANCH;
        const_d        = {{38{ir_q[25]}}, ir_q[25:0]};
        if (ir_q[31]) begin
          exec_cw.en_pc = 1'b1;
          exec_cw.wr    = 1'b1;
          exec_cw.da    = LINK_DA;
        end
      end
      11'b1011010????: begin
        // ir_q[24] distinguishes CBNZ, inverting the sense of the live zero flag.
        exec_cw.fs     = FS_OR;
        exec_cw.sa     = ir_q[4:0];
        exec_cw.sb     = XZR;
        exec_cw.pc_sel = 1'b1;
        exec_cw.ps     = (status_i[0] ^ ir_q[24]) ? PS_BRANCH : PS_INC;
        const_d        = {{45{ir_q[23]}}, ir_q[23:5]};
      end
`ifdef FLAG_BRANCH_EN
      11'b01010100???: begin
        exec_cw.pc_sel = 1'b1;
        exec_cw.ps     = cond_taken(ir_q[3:0], status_i[4:1]) ? PS_BRANCH : PS_INC;
        const_d        = {{45{ir_q[23]}}, ir_q[23:5]};
      end
`endif
      11'b110100101??: begin
        exec_cw.fs     = FS_OR;
        exec_cw.sa     = XZR;
        exec_cw.b_sel  = 1'b1;
        exec_cw.en_alu = 1'b1;
        exec_cw.wr     = 1'b1;
        exec_cw.da     = ir_q[4:0];
        exec_cw.ps     = PS_INC;
        const_d        = 64'(ir_q[20:5]) << {ir_q[22:21], 4'b0000};
      end
      11'b1001000100?: begin exec_cw.fs = FS_ADD; alu_ri = 1'b1; end
      11'b1101000100?: begin exec_cw.fs = FS_SUB; alu_ri = 1'b1; end
      11'b1001001000?: begin exec_cw.fs = FS_AND; alu_ri = 1'b1; end
      11'b1011001000?: begin exec_cw.fs = FS_OR;  alu_ri = 1'b1; end
      11'b1101001000?: begin exec_cw.fs = FS_XOR; alu_ri = 1'b1; end
      11'b10001011000: begin exec_cw.fs = FS_ADD; alu_rr = 1'b1; end
      11'b11001011000: begin exec_cw.fs = FS_SUB; alu_rr = 1'b1; end
      11'b10001010000: begin exec_cw.fs = FS_AND; alu_rr = 1'b1; end
      11'b10101010000: begin exec_cw.fs = FS_OR;  alu_rr = 1'b1; end
      11'b11001010000: begin exec_cw.fs = FS_XOR; alu_rr = 1'b1; end
      11'b10101011000: begin exec_cw.fs = FS_ADD; exec_cw.sl = 1'b1; alu_rr = 1'b1; end
      11'b11101011000: begin exec_cw.fs = FS_SUB; exec_cw.sl = 1'b1; alu_rr = 1'b1; end
      11'b11010011011: begin exec_cw.fs = FS_LSL; alu_rr = 1'b1; end
      11'b11010011010: begin exec_cw.fs = FS_LSR; alu_rr = 1'b1; end
      11'b11010110000: begin
        exec_cw.sa = ir_q[9:5];
        exec_cw.ps = PS_REG;
      end
      11'b11111000010, 11'b11111000000: begin
        exec_cw.fs    = FS_ADD;
        exec_cw.b_sel = 1'b1;
        exec_cw.sa    = ir_q[9:5];
        exec_cw.ps    = PS_INC;
        const_d       = {{55{ir_q[20]}}, ir_q[20:12]};
        if (ir_q[22]) begin
          exec_cw.en_mem = 1'b1;
          exec_cw.wr     = 1'b1;
          exec_cw.da     = ir_q[4:0];
        end else begin
          exec_cw.wm = 1'b1;
          exec_cw.sb = ir_q[4:0];
        end
      end
      default: valid = 1'b0;
    endcase

    if (alu_rr || alu_ri) begin
      exec_cw.en_alu = 1'b1;
      exec_cw.wr     = 1'b1;
      exec_cw.da     = ir_q[4:0];
      exec_cw.sa     = ir_q[9:5];
      exec_cw.sb     = ir_q[20:16];
      exec_cw.b_sel  = alu_ri;
      exec_cw.ps     = PS_INC;
      // Shift forms carry shamt in the constant; I-type carries imm12.
      const_d        = alu_ri ? 64'(ir_q[21:10]) : 64'(ir_q[15:10]);
    end
  end

  // NOTE: the async reset forces FETCH, so the combinational control word drops to zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      constant_q <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          ir_q    <= instruction_i;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          constant_q <= const_d;
          state_q    <= valid ? S_EXECUTE : S_HALT;
        end
        S_EXECUTE: state_q <= S_FETCH;
        default:   state_q <= S_HALT;
      endcase
    end
  end

  assign control_word_o = (state_q == S_EXECUTE) ? exec_cw : '0;
  assign constant_o     = constant_q;
  assign state_o        = state_q;
  assign halt_o         = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer_legv8.sv
// Directed, table-driven bench for control_sequencer_legv8 with hand-encoded LEGv8 words
// and hand-computed control words; multi-cycle halt and reset corners are written out.
module tb_control_sequencer_legv8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic [4:0]  status = '0;
  logic [29:0] control_word;
  logic [63:0] constant;
  logic [1:0]  state;
  logic        halt;

  int checks = 0;
  int errors = 0;

  control_sequencer_legv8 #(.LINK_REG(30)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instruction_i  (instruction),
    .status_i       (status),
    .control_word_o (control_word),
    .constant_o     (constant),
    .state_o        (state),
    .halt_o         (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  status;
    logic        exp_halt;
    logic [29:0] exp_cw;
    logic [63:0] exp_const;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] cw(input logic en_pc, en_mem, en_alu, pc_sel, b_sel, sl, wm, wr,
                                     input logic [1:0] ps, input logic [4:0] fs, sb, sa, da);
    return {en_pc, en_mem, en_alu, pc_sel, b_sel, sl, wm, wr, ps, fs, sb, sa, da};
  endfunction

  task automatic add(input string name, input logic [31:0] instr, input logic [4:0] st,
                     input logic h, input logic [29:0] c, input logic [63:0] k);
    vec_t v;
    v.name = name; v.instr = instr; v.status = st;
    v.exp_halt = h; v.exp_cw = c; v.exp_const = k;
    vecs.push_back(v);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    add("addi",  32'h910017E1, 5'b00000, 1'b0, cw(0,0,1,0,1,0,0,1,2'b01,5'b01000,5'd0,5'd31,5'd1), 64'd5);
    add("subs",  32'hEB010022, 5'b00000, 1'b0, cw(0,0,1,0,0,1,0,1,2'b01,5'b01001,5'd1,5'd1,5'd2), 64'd0);
`ifdef FLAG_BRANCH_EN
    add("b_eq_taken", 32'h54FFFFA0, 5'b00010, 1'b0, cw(0,0,0,1,0,0,0,0,2'b11,5'd0,5'd0,5'd0,5'd0), 64'hFFFF_FFFF_FFFF_FFFD);
    add("b_ne_not",   32'h54FFFFA1, 5'b00010, 1'b0, cw(0,0,0,1,0,0,0,0,2'b01,5'd0,5'd0,5'd0,5'd0), 64'hFFFF_FFFF_FFFF_FFFD);
    add("b_gt_taken", 32'h54FFFFAC, 5'b10100, 1'b0, cw(0,0,0,1,0,0,0,0,2'b11,5'd0,5'd0,5'd0,5'd0), 64'hFFFF_FFFF_FFFF_FFFD);
`else
    add("b_eq_halt",  32'h54FFFFA0, 5'b00010, 1'b1, 30'd0, 64'd0);
`endif
    add("add",   32'h8B050083, 5'b00000, 1'b0, cw(0,0,1,0,0,0,0,1,2'b01,5'b01000,5'd5,5'd4,5'd3), 64'd0);
    add("and",   32'h8A0800E6, 5'b00000, 1'b0, cw(0,0,1,0,0,0,0,1,2'b01,5'b00000,5'd8,5'd7,5'd6), 64'd0);
    add("orr",   32'hAA0B0149, 5'b00000, 1'b0, cw(0,0,1,0,0,0,0,1,2'b01,5'b00100,5'd11,5'd10,5'd9), 64'd0);
    add("eor",   32'hCA030041, 5'b00000, 1'b0, cw(0,0,1,0,0,0,0,1,2'b01,5'b01100,5'd3,5'd2,5'd1), 64'd0);
    add("sub",   32'hCB030041, 5'b00001, 1'b0, cw(0,0,1,0,0,0,0,1,2'b01,5'b01001,5'd3,5'd2,5'd1), 64'd0);
    add("lsl",   32'hD3601041, 5'b00000, 1'b0, cw(0,0,1,0,0,0,0,1,2'b01,5'b10000,5'd0,5'd2,5'd1), 64'd4);
    add("ldur",  32'hF85F80C5, 5'b00000, 1'b0, cw(0,1,0,0,1,0,0,1,2'b01,5'b01000,5'd0,5'd6,5'd5), 64'hFFFF_FFFF_FFFF_FFF8);
    add("stur",  32'hF8010107, 5'b00000, 1'b0, cw(0,0,0,0,1,0,1,0,2'b01,5'b01000,5'd7,5'd8,5'd0), 64'd16);
    add("bl",    32'h94000010, 5'b00000, 1'b0, cw(1,0,0,1,0,0,0,1,2'b11,5'd0,5'd0,5'd0,5'd30), 64'd16);
    add("b",     32'h17FFFFFC, 5'b00000, 1'b0, cw(0,0,0,1,0,0,0,0,2'b11,5'd0,5'd0,5'd0,5'd0), 64'hFFFF_FFFF_FFFF_FFFC);
    add("br",    32'hD60003C0, 5'b00000, 1'b0, cw(0,0,0,0,0,0,0,0,2'b10,5'd0,5'd0,5'd30,5'd0), 64'd0);
    add("cbz_nt",  32'hB4FFFFC3, 5'b00000, 1'b0, cw(0,0,0,1,0,0,0,0,2'b01,5'b00100,5'd31,5'd3,5'd0), 64'hFFFF_FFFF_FFFF_FFFE);
    add("cbz_t",   32'hB4FFFFC3, 5'b00001, 1'b0, cw(0,0,0,1,0,0,0,0,2'b11,5'b00100,5'd31,5'd3,5'd0), 64'hFFFF_FFFF_FFFF_FFFE);
    add("cbnz_nt", 32'hB5FFFFC3, 5'b00001, 1'b0, cw(0,0,0,1,0,0,0,0,2'b01,5'b00100,5'd31,5'd3,5'd0), 64'hFFFF_FFFF_FFFF_FFFE);
    add("cbnz_t",  32'hB5FFFFC3, 5'b00000, 1'b0, cw(0,0,0,1,0,0,0,0,2'b11,5'b00100,5'd31,5'd3,5'd0), 64'hFFFF_FFFF_FFFF_FFFE);
    add("movz",  32'hD2A24684, 5'b00000, 1'b0, cw(0,0,1,0,1,0,0,1,2'b01,5'b00100,5'd0,5'd31,5'd4), 64'h0000_0000_1234_0000);
    add("zero_halt", 32'h00000000, 5'b00000, 1'b1, 30'd0, 64'd0);

    // Reset held low: outputs must sit at their reset values even with clocks running.
    instruction = 32'h910017E1;
    tick();
    tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_cw", 64'(control_word), 64'd0);
    check("rst_const", constant, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      instruction = vecs[i].instr;
      status = vecs[i].status;
      #1;
      check({vecs[i].name, "_fetch_state"}, 64'(state), 64'd0);
      check({vecs[i].name, "_fetch_cw"}, 64'(control_word), 64'd0);
      tick();
      check({vecs[i].name, "_decode_state"}, 64'(state), 64'd1);
      check({vecs[i].name, "_decode_cw"}, 64'(control_word), 64'd0);
      tick();
      if (vecs[i].exp_halt) begin
        check({vecs[i].name, "_halt_state"}, 64'(state), 64'd3);
        check({vecs[i].name, "_halt"}, 64'(halt), 64'd1);
        check({vecs[i].name, "_halt_cw"}, 64'(control_word), 64'd0);
        pulse_reset();
      end else begin
        check({vecs[i].name, "_exec_state"}, 64'(state), 64'd2);
        check({vecs[i].name, "_exec_cw"}, 64'(control_word), 64'(vecs[i].exp_cw));
        check({vecs[i].name, "_exec_const"}, constant, vecs[i].exp_const);
        check({vecs[i].name, "_onehot_en"},
              64'(int'(control_word[29]) + int'(control_word[28]) + int'(control_word[27]) <= 1), 64'd1);
        tick();
      end
    end

    // HALT is absorbing for ten cycles, then reset returns to FETCH.
    instruction = 32'h00000000;
    status = 5'b11111;
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("halt_hold_%0d", c), {62'd0, halt, 1'b0} | 64'(control_word != '0), 64'd2);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("halt_rst_state", 64'(state), 64'd0);
    check("halt_rst_halt", 64'(halt), 64'd0);
    rst_n = 1'b1;

    // Reset dropped mid-EXECUTE of STUR kills WM immediately; first FETCH follows release.
    instruction = 32'hF8010107;
    status = 5'b00000;
    tick();
    tick();
    check("stur_exec_wm", 64'(control_word[23]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("stur_rst_wm", 64'(control_word[23]), 64'd0);
    check("stur_rst_cw", 64'(control_word), 64'd0);
    check("stur_rst_state", 64'(state), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("stur_release_state", 64'(state), 64'd0);
    tick();
    check("stur_release_decode", 64'(state), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
